mult_share_ctrl: RTL
====================

Name: mult_share_ctrl

Overview:
- Shares one iterative unsigned shift-add multiplier between NREQ requesters; one shift-add step per clock.
- Round-robin arbitration, a valid/ready handshake per requester, and a single valid/ready response port tagged with the requester id.
- Sits between client blocks and the multiplier datapath; it is the only path into the multiplier.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), id width; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_opa  in  NREQ*WIDTH  multiplicands; slice i belongs to requester i
- req_opb  in  NREQ*WIDTH  multipliers; slice i belongs to requester i
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_result  out  2*WIDTH  unsigned product opa*opb
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0. An in-flight operation is discarded and no response is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: grant goes to the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[grant]=1, combinational, IDLE only; all other bits 0.
  - On the accepting edge, latch shift_opa={WIDTH'b0,opa}, shift_opb=opb, acc=0, id=grant, cnt=WIDTH-1.
  - Also set rr_ptr=(grant+1) mod NREQ, then go to RUN.
  - No request: stay in IDLE.
- RUN, each edge:
  - If shift_opb[0], acc+=shift_opa.
  - shift_opa<<=1, shift_opb>>=1.
  - If cnt==0, go to DONE; else cnt-=1.
- Latency: rsp_valid rises exactly WIDTH edges after the accepting edge.
- DONE:
  - rsp_valid=1; rsp_result=acc; rsp_id=id. All three are held stable until the handshake.
  - On rsp_valid&&rsp_ready, go to IDLE. No accept in that cycle, giving minimum throughput of one op per WIDTH+2 cycles.
- Arithmetic: unsigned and exact; acc is 2*WIDTH bits and never overflows.
  - Example boundary: (2^WIDTH-1)^2 = 0xFE01 for WIDTH=8.
- req_valid may drop before grant without penalty. Operands are sampled only on the accepting edge.
- All requesters valid continuously: grants rotate 0,1,2,3,0,… with no starvation.
- rsp_ready held low: the block stalls in DONE indefinitely and req_ready stays 0.
- NREQ not a power of two: ids ≥ NREQ are never produced; rr_ptr wraps from NREQ-1 to 0.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: RUN also exits to DONE on the edge where the post-shift shift_opb==0.
  - Latency = index of the highest set bit of opb, plus 1.
  - opb==0 gives latency 1.
  - Results are identical to the non-macro build.
- Undefined: latency is fixed at WIDTH.

Decomposition:
- Package mult_share_pkg holds:
  - state enum typedef (IDLE/RUN/DONE);
  - default WIDTH/NREQ localparams;
  - the function for round-robin first-set search.
- One sub-module, mult_step_dp, holds shift_opa/shift_opb/acc and performs load and step. Its controls are load, step and done_early.
- The FSM, counter, arbiter and response registers stay in mult_share_ctrl.

Test Plan:
- Reset then req_valid[2]=1, opa=13, opb=11 -> req_ready=0b0100 in the same cycle; rsp_valid 8 edges later; rsp_result=143; rsp_id=2.
- opa=255, opb=255 -> rsp_result=0xFE01. opa=0 or opb=0 -> 0.
- All four req_valid held high, rsp_ready=1 -> successive rsp_id 0,1,2,3,0. Each result matches its own operands.
- rsp_ready=0 for 20 cycles in DONE -> rsp_valid/result/id stable, req_ready=0, busy=1. Then rsp_ready=1 -> IDLE the next cycle.
- rst asserted at cycle 4 of RUN, async mid-cycle -> outputs zero immediately; no response for the dropped op; next grant starts searching at requester 0.
- MULT_EARLY_EXIT_EN: opb=1 -> latency 1; opb=0x10 -> 5; opb=0x80 -> 8. Products match the non-macro build.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the round-robin multiplier-sharing controller.
package mult_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int MAX_NREQ  = 16;

    // First set bit of vld at or above ptr, wrapping within n; -1 when none is set.
    function automatic int rr_first(input logic [MAX_NREQ-1:0] vld, input int ptr, input int n);
        int res;
        int idx;
        res = -1;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (vld[idx]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_step_dp.sv
// Shift-add multiplier datapath: one load, then one partial-product step per enabled clock.
module mult_step_dp
    import mult_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_opa,
    input  logic [WIDTH-1:0]   i_opb,
    output logic [2*WIDTH-1:0] o_acc_next,
    output logic               o_done_early
);

    logic [2*WIDTH-1:0] r_shift_opa;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_shift_opb;
    logic [2*WIDTH-1:0] w_addend;

    // Partial product contributed by the current multiplier bit.
    always_comb begin
        if (r_shift_opb[0]) begin
            w_addend = r_shift_opa;
        end else begin
            w_addend = {(2*WIDTH){1'b0}};
        end
    end

    assign o_acc_next   = r_acc + w_addend;
    // True when no multiplier bits remain after this step's shift.
    assign o_done_early = ((r_shift_opb >> 1) == {WIDTH{1'b0}});

    // Operand shift registers and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_opa <= {(2*WIDTH){1'b0}};
            r_shift_opb <= {WIDTH{1'b0}};
            r_acc       <= {(2*WIDTH){1'b0}};
        end else if (i_load) begin
            r_shift_opa <= {{WIDTH{1'b0}}, i_opa};
            r_shift_opb <= i_opb;
            r_acc       <= {(2*WIDTH){1'b0}};
        end else if (i_step) begin
            r_shift_opa <= r_shift_opa << 1;
            r_shift_opb <= r_shift_opb >> 1;
            r_acc       <= o_acc_next;
        end else begin
            r_shift_opa <= r_shift_opa;
            r_shift_opb <= r_shift_opb;
            r_acc       <= r_acc;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin front end sharing one iterative multiplier among NREQ requesters.
// Build option: define MULT_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = $clog2(NREQ)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_opa,
    input  logic [NREQ*WIDTH-1:0] req_opb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_result,
    output logic                  busy
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic [CNTW-1:0]    r_cnt;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_result;
    logic               r_busy;

    int                 w_idx;
    logic               w_found;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_ptr_next;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_done_early;
    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_idx      = rr_first(MAX_NREQ'(req_valid), int'(r_rr_ptr), NREQ);
    assign w_found    = (w_idx >= 0);
    assign w_grant    = IDW'(w_idx);
    assign w_ptr_next = (w_grant == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (w_grant + IDW'(1));
    assign w_accept   = (r_state == ST_IDLE) && w_found;
    assign w_step     = (r_state == ST_RUN);
    assign w_last     = (r_cnt == {CNTW{1'b0}}) || (EARLY_EN && w_done_early);
    assign w_opa      = req_opa[int'(w_grant)*WIDTH +: WIDTH];
    assign w_opb      = req_opb[int'(w_grant)*WIDTH +: WIDTH];

    // Grant is only offered while idle, so a finished result blocks new work until it is taken.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    mult_step_dp #(
        .WIDTH        (WIDTH)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_step       (w_step),
        .i_opa        (w_opa),
        .i_opb        (w_opb),
        .o_acc_next   (w_acc_next),
        .o_done_early (w_done_early)
    );

    // Control FSM with arbitration pointer, step counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= {IDW{1'b0}};
            r_id         <= {IDW{1'b0}};
            r_cnt        <= {CNTW{1'b0}};
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= {IDW{1'b0}};
            r_rsp_result <= {(2*WIDTH){1'b0}};
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id     <= w_grant;
                        r_cnt    <= CNTW'(WIDTH - 1);
                        r_rr_ptr <= w_ptr_next;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_id;
                        r_rsp_result <= w_acc_next;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt        <= r_cnt - CNTW'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;

endmodule
